// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Define ALU_SIGNED_MULDIV_EN to enable signed MULS (1001) and DIVS (0100).
module alu_multicycle #(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   read_data_1,
    input  logic [WIDTH-1:0]   reg_mux,
    input  logic [3:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               zero,
    output logic               c_out,
    output logic               div_by_zero,
    output logic               illegal_op
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MULS = 4'b1001;
    localparam logic [3:0] OP_DIVS = 4'b0100;
`endif
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_hi_q, neg_hi_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               zero_q, zero_d;
    logic               c_out_q, c_out_d;
    logic               dbz_q, dbz_d;
    logic               ill_q, ill_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH:0]     add_sum, sub_diff, mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_step, div_step;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign add_sum  = {1'b0, read_data_1} + {1'b0, reg_mux};
    assign sub_diff = {1'b0, read_data_1} + {1'b0, ~reg_mux} + (WIDTH+1)'(1);

    // work_q holds {partial product, remaining multiplier bits} during MUL
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, work_q[WIDTH-1:1]};

    // work_q holds {partial remainder, dividend bits / quotient} during DIV
    assign div_trial = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_step  = div_trial[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    assign quo_fix   = neg_hi_q  ? -div_step[WIDTH-1:0]         : div_step[WIDTH-1:0];
    assign rem_fix   = neg_rem_q ? -div_step[2*WIDTH-1:WIDTH]   : div_step[2*WIDTH-1:WIDTH];

`ifdef ALU_SIGNED_MULDIV_EN
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sgn_a, sgn_b;
    assign sgn_a = read_data_1[WIDTH-1];
    assign sgn_b = reg_mux[WIDTH-1];
    assign mag_a = sgn_a ? -read_data_1 : read_data_1;
    assign mag_b = sgn_b ? -reg_mux : reg_mux;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        neg_hi_d  = neg_hi_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        zero_d    = zero_q;
        c_out_d   = c_out_q;
        dbz_d     = dbz_q;
        ill_d     = ill_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_DONE;
                    cnt_d     = ITER_LAST;
                    neg_hi_d  = 1'b0;
                    neg_rem_d = 1'b0;
                    result_d  = '0;
                    c_out_d   = 1'b0;
                    dbz_d     = 1'b0;
                    ill_d     = 1'b0;
                    case (opcode)
                        OP_AND: result_d = {{WIDTH{1'b0}}, read_data_1 & reg_mux};
                        OP_OR:  result_d = {{WIDTH{1'b0}}, read_data_1 | reg_mux};
                        OP_NOR: result_d = {{WIDTH{1'b0}}, ~(read_data_1 | reg_mux)};
                        OP_ADD: begin
                            result_d = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                            c_out_d  = add_sum[WIDTH];
                        end
                        OP_SUB: begin
                            result_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                            c_out_d  = sub_diff[WIDTH];
                        end
                        OP_SLT: result_d[0] = $signed(read_data_1) < $signed(reg_mux);
                        OP_MUL: begin
                            state_d = S_MUL;
                            work_d  = {{WIDTH{1'b0}}, reg_mux};
                            opnd_d  = read_data_1;
                        end
                        OP_DIV: begin
                            if (reg_mux == '0) begin
                                result_d = {read_data_1, {WIDTH{1'b1}}};
                                dbz_d    = 1'b1;
                            end else begin
                                state_d = S_DIV;
                                work_d  = {{WIDTH{1'b0}}, read_data_1};
                                opnd_d  = reg_mux;
                            end
                        end
`ifdef ALU_SIGNED_MULDIV_EN
                        OP_MULS: begin
                            state_d  = S_MUL;
                            work_d   = {{WIDTH{1'b0}}, mag_b};
                            opnd_d   = mag_a;
                            neg_hi_d = sgn_a ^ sgn_b;
                        end
                        OP_DIVS: begin
                            if (reg_mux == '0) begin
                                result_d = {read_data_1, {WIDTH{1'b1}}};
                                dbz_d    = 1'b1;
                            end else begin
                                state_d   = S_DIV;
                                work_d    = {{WIDTH{1'b0}}, mag_a};
                                opnd_d    = mag_b;
                                neg_hi_d  = sgn_a ^ sgn_b;
                                neg_rem_d = sgn_a;
                            end
                        end
`endif
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = neg_hi_q ? -mul_step : mul_step;
                end else begin
                    work_d = mul_step;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = {rem_fix, quo_fix};
                end else begin
                    work_d = div_step;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE && state_q != S_DONE) zero_d = (result_d == '0);
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            opnd_q      <= '0;
            neg_hi_q    <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            c_out_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            opnd_q      <= opnd_d;
            neg_hi_q    <= neg_hi_d;
            neg_rem_q   <= neg_rem_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            c_out_q     <= c_out_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign c_out       = c_out_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, corner sequences, random vs model.
module tb_alu_multicycle;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   read_data_1;
    logic [W-1:0]   reg_mux;
    logic [3:0]     opcode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           zero;
    logic           c_out;
    logic           div_by_zero;
    logic           illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .read_data_1(read_data_1), .reg_mux(reg_mux), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .c_out(c_out), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           c;
        logic           dbz;
        logic           ill;
        int             lat;
        int             hold;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2*W-1:0] res, input logic c, input logic dbz,
                                input logic ill, input int lat, input int hold);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.c = c; v.dbz = dbz; v.ill = ill;
        v.lat = lat; v.hold = hold;
        return v;
    endfunction

    task automatic chkw(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model from arithmetic rules, independent of how the iterations are done.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2*W-1:0] r, output logic c, output logic dbz,
                                  output logic ill, output int lat);
        logic [W:0] s;
        r = '0; c = 1'b0; dbz = 1'b0; ill = 1'b0; lat = 1;
        case (op)
            4'b0000: r = {{W{1'b0}}, a & b};
            4'b0001: r = {{W{1'b0}}, a | b};
            4'b1100: r = {{W{1'b0}}, ~(a | b)};
            4'b0010: begin s = {1'b0, a} + {1'b0, b}; r = {{W{1'b0}}, s[W-1:0]}; c = s[W]; end
            4'b0110: begin r = {{W{1'b0}}, a - b}; c = (a >= b); end
            4'b0111: r = {{(2*W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1000: begin r = {{W{1'b0}}, a} * {{W{1'b0}}, b}; lat = W + 1; end
            4'b0011: begin
                if (b == '0) begin r = {a, {W{1'b1}}}; dbz = 1'b1; end
                else begin r = {a % b, a / b}; lat = W + 1; end
            end
`ifdef ALU_SIGNED_MULDIV_EN
            4'b1001: begin
                r = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                lat = W + 1;
            end
            4'b0100: begin
                if (b == '0) begin r = {a, {W{1'b1}}}; dbz = 1'b1; end
                else begin
                    lat = W + 1;
                    if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) r = {{W{1'b0}}, a};
                    else r = {W'($signed(a) % $signed(b)), W'($signed(a) / $signed(b))};
                end
            end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] er, input logic ec, input logic edbz,
                          input logic eill, input int elat, input int hold);
        int guard;
        int lat;
        logic busy_ok;
        logic stable_ok;
        logic [2*W-1:0] held;
        logic [3:0] held_flags;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chkb("in_ready_before_issue", in_ready, 1'b1);
        in_valid = 1'b1; opcode = op; read_data_1 = a; reg_mux = b; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 4'($urandom);
        read_data_1 = {$urandom, $urandom};
        reg_mux = {$urandom, $urandom};
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chkb("in_ready_low_while_busy", busy_ok & ~in_ready, 1'b1);
        chki("latency", lat, elat);
        chkw("result", result, er);
        chkb("c_out", c_out, ec);
        chkb("zero", zero, (er == '0));
        chkb("div_by_zero", div_by_zero, edbz);
        chkb("illegal_op", illegal_op, eill);
        held = result;
        held_flags = {zero, c_out, div_by_zero, illegal_op};
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (result !== held || {zero, c_out, div_by_zero, illegal_op} !== held_flags ||
                out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        if (hold > 0) chkb("held_under_backpressure", stable_ok, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chkb("out_valid_after_handshake", out_valid, 1'b0);
        chkb("in_ready_after_handshake", in_ready, 1'b1);
    endtask

    initial begin
        logic [2*W-1:0] mr;
        logic mc, mdbz, mill;
        int mlat;
        logic seen_valid;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; read_data_1 = '0; reg_mux = '0;
        #1;
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_out_valid", out_valid, 1'b0);
        chkw("rst_result", result, '0);
        chkb("rst_zero", zero, 1'b0);
        chkb("rst_c_out", c_out, 1'b0);
        chkb("rst_flags", div_by_zero | illegal_op, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        vecs.push_back(mk(4'b0010, 64'd53, 64'd100, 128'd153, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0110, 64'd545, 64'd545, 128'd0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'd0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0110, 64'd3, 64'd5, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b1000, 64'd600, 64'd54, 128'd32400, 0, 0, 0, 65, 0));
        vecs.push_back(mk(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0, 0, 0, 65, 0));
        vecs.push_back(mk(4'b1000, 64'd7, 64'd0, 128'd0, 0, 0, 0, 65, 0));
        vecs.push_back(mk(4'b0011, 64'd500, 64'd20, 128'd25, 0, 0, 0, 65, 0));
        vecs.push_back(mk(4'b0011, 64'd5, 64'd7, {64'd5, 64'd0}, 0, 0, 0, 65, 0));
        vecs.push_back(mk(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 0, 0, 0, 65, 0));
        vecs.push_back(mk(4'b0011, 64'd7, 64'd0, {64'd7, 64'hFFFF_FFFF_FFFF_FFFF}, 0, 1, 0, 1, 0));
        vecs.push_back(mk(4'b0000, 64'hCD, 64'hE6, 128'hC4, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0001, 64'hCD, 64'hE6, 128'hEF, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b1100, 64'hCD, 64'hE6, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FF10, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b1111, 64'hCD, 64'hE6, 128'd0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 128'd1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(4'b0111, 64'd5, 64'd3, 128'd0, 0, 0, 0, 1, 0));
`ifndef ALU_SIGNED_MULDIV_EN
        vecs.push_back(mk(4'b1001, 64'd3, 64'd4, 128'd0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(4'b0100, 64'd8, 64'd2, 128'd0, 0, 0, 1, 1, 0));
`endif
        // MUL held under backpressure for 10 cycles after completion
        vecs.push_back(mk(4'b1000, 64'd12345, 64'd678, 128'd8369910, 0, 0, 0, 65, 10));

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c,
                   vecs[i].dbz, vecs[i].ill, vecs[i].lat, vecs[i].hold);

        // Reset 20 cycles into a DIV: aborts with nothing emitted
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'b0011; read_data_1 = 64'd1000; reg_mux = 64'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chkb("abort_out_valid", out_valid, 1'b0);
        chkb("abort_in_ready", in_ready, 1'b1);
        chkw("abort_result", result, '0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chkb("abort_no_result_emitted", seen_valid, 1'b0);
        out_ready = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            logic [W-1:0] a, b;
            case ($urandom_range(0, 3))
                0: op = 4'b1000;
                1: op = 4'b0011;
                default: op = 4'($urandom_range(0, 15));
            endcase
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) a = b;
            model(op, a, b, mr, mc, mdbz, mill, mlat);
            run_op(op, a, b, mr, mc, mdbz, mill, mlat, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised successor to the single-cycle 64-bit MIPS ALU. Keeps the same opcode encoding. Adds valid/ready handshakes on input and output, and executes MUL/DIV iteratively (shift-add multiply, restoring divide) so they do not sit in the execute-stage critical path. It sits between the register-read/operand mux and writeback; the pipeline stalls on in_ready/out_valid.

Parameters:
WIDTH, 64, operand width in bits (must be ≥4 and even); result is 2*WIDTH.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept a new operation
read_data_1  input  WIDTH  operand A (dividend / multiplicand)
reg_mux  input  WIDTH  operand B (divisor / multiplier)
opcode  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 MUL, 0011 DIV, 1100 NOR, 0111 SLT
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  result, held stable while out_valid && !out_ready
zero  output  1  result == 0 (all 2*WIDTH bits)
c_out  output  1  carry out of ADD; borrow-free flag (carry) of SUB; 0 otherwise
div_by_zero  output  1  DIV issued with reg_mux == 0
illegal_op  output  1  unrecognised opcode

Behaviour:
- Reset (async, active-high): state IDLE; in_ready=1; out_valid=0; result=0; zero=0; c_out=0; div_by_zero=0; illegal_op=0; counter=0. Reset mid-MUL/DIV aborts the operation with no output.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: in_ready=1; accept on in_valid && in_ready. Operands and opcode are latched.
  - Logic/ADD/SUB/NOR/SLT/illegal -> DONE.
  - MUL -> MUL; DIV with reg_mux!=0 -> DIV; DIV with reg_mux==0 -> DONE.
- in_ready=0 in MUL, DIV and DONE; no overlap of operations.
- Single-cycle ops: out_valid rises on the first clk edge after acceptance (latency 1).
- ADD/SUB: WIDTH-bit result, zero-extended into result[2W-1:0]; c_out = carry out of A+B / A+~B+1.
- SLT: signed compare, result = 1 or 0.
- Illegal opcode: result=0, illegal_op=1, zero=1.
- MUL: unsigned, one multiplier bit per cycle, WIDTH iterations, then DONE. out_valid rises WIDTH+1 edges after acceptance. result = full 2*WIDTH-bit product.
- DIV: unsigned restoring, one quotient bit per cycle, WIDTH iterations, same latency as MUL. result = {remainder, quotient}: remainder in upper WIDTH bits, quotient in lower WIDTH bits.
- Divide by zero: latency 1; quotient = all ones, remainder = read_data_1, div_by_zero=1.
- DONE: out_valid=1; all outputs held stable until out_ready. On out_valid && out_ready -> IDLE (in_ready=1 next cycle). Back-to-back throughput for single-cycle ops is one operation per 2 cycles.
- Flags (zero, c_out, div_by_zero, illegal_op) are registered with result and valid only while out_valid=1.
- Changes on read_data_1/reg_mux/opcode after acceptance have no effect.

Optional Feature:
ALU_SIGNED_MULDIV_EN.
- Defined: opcodes 1001 MULS and 0100 DIVS are legal and have the same latency as MUL/DIV. Operands are converted to magnitude before iteration and the sign is fixed up in DONE entry.
  - MULS: 2*WIDTH signed product.
  - DIVS: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVS by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
  - Most-negative / -1: quotient = most-negative, remainder = 0, no flag.
- Not defined: 1001 and 0100 are illegal opcodes (illegal_op=1, result=0).

Test Plan:
1. ADD 53+100 with out_ready=1 -> out_valid one edge after accept; result=153, c_out=0, zero=0; in_ready high the cycle after the handshake.
2. SUB 545-545 -> result=0, zero=1, c_out=1. ADD 0xFFFF_FFFF_FFFF_FFFF+1 -> result=0, c_out=1.
3. MUL 600*54 -> in_ready=0 for 64 cycles; out_valid 65 edges after accept; result=32400. MUL (2^64-1)*(2^64-1) -> result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
4. DIV 500/20 -> result lower=25, upper=0. DIV 7/0 -> latency 1; lower=all ones, upper=7, div_by_zero=1.
5. AND 0xCD,0xE6 -> 0xC4; OR -> 0xEF; NOR -> ~0xEF zero-extended. opcode 1111 -> illegal_op=1, result=0.
6. Backpressure and reset:
   - Hold out_ready=0 for 10 cycles after MUL completes -> result/flags stable, in_ready=0; then out_ready=1 -> IDLE.
   - Assert reset 20 cycles into a DIV -> out_valid=0, in_ready=1 immediately, no result ever emitted.
